// File: rtl/host_word_assembler.sv
// host_word_assembler: packs six UART bytes into a 48-bit word held under a clearDR four-phase handshake
module host_word_assembler #(
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic        masterClock,
  input  logic        reset,
  input  logic        rxByteValid,
  input  logic [7:0]  rxByte,
  input  logic        clearDR,
  output logic        dataReceived,
  output logic [47:0] inputData,
  output logic [2:0]  byteCount,
  output logic        overrun,
  output logic        timeoutPulse
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAST_IDLE = CW'(TIMEOUT_CYCLES - 1);
  typedef enum logic [1:0] {COLLECT, FULL, RELEASE} state_t;
  state_t r_state, w_state;
  logic [39:0]   r_shift, w_shift;
  logic [CW-1:0] r_idle, w_idle;
  logic [47:0]   w_data;
  logic [2:0]    w_cnt;
  logic          w_dr, w_ovr, w_to;
  always_ff @(posedge masterClock) begin
    if (reset) begin
      r_state      <= COLLECT;
      r_shift      <= '0;
      r_idle       <= '0;
      inputData    <= '0;
      byteCount    <= '0;
      dataReceived <= 1'b0;
      overrun      <= 1'b0;
      timeoutPulse <= 1'b0;
    end else begin
      r_state      <= w_state;
      r_shift      <= w_shift;
      r_idle       <= w_idle;
      inputData    <= w_data;
      byteCount    <= w_cnt;
      dataReceived <= w_dr;
      overrun      <= w_ovr;
      timeoutPulse <= w_to;
    end
  end
  always_comb begin
    w_state = r_state;
    w_shift = r_shift;
    w_idle  = r_idle;
    w_data  = inputData;
    w_cnt   = byteCount;
    w_dr    = dataReceived;
    w_ovr   = overrun;
    w_to    = 1'b0;
    case (r_state)
      COLLECT: begin
        if (rxByteValid) begin
          w_shift = {r_shift[31:0], rxByte};
          w_idle  = '0;
          if (byteCount == 3'd5) begin
            w_data  = {r_shift, rxByte};
            w_dr    = 1'b1;
            w_cnt   = 3'd0;
            w_state = FULL;
          end else begin
            w_cnt = byteCount + 3'd1;
          end
        end else if (byteCount != 3'd0) begin
          // a byte landing on the expiring cycle is handled above, so it wins over the timeout
          w_idle = (r_idle == LAST_IDLE) ? '0 : r_idle + 1'b1;
          w_cnt  = (r_idle == LAST_IDLE) ? 3'd0 : byteCount;
          w_to   = (r_idle == LAST_IDLE);
        end
      end
      FULL: begin
        w_ovr   = overrun | rxByteValid;
        w_dr    = clearDR ? 1'b0 : dataReceived;
        w_state = clearDR ? RELEASE : FULL;
      end
      default: begin
        w_ovr   = overrun | rxByteValid;
        w_state = clearDR ? RELEASE : COLLECT;
      end
    endcase
  end
endmodule
